reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: ReorderBuffer

---
 rtl/reorder_buffer.sv | 145 ++++++++++++++
 tb/tb_reorder_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with in-order commit and branch-mispredict flush.
// Optional feature: define ROB_FORWARD_EN for the combinational result-forwarding lookup.
module reorder_buffer #(
  parameter int RoB_WIDTH = 8,
  parameter int RoB_SIZE = 1 << RoB_WIDTH,
  parameter int EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_branch,
  input  logic                    DPRoB_pred_jump,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_RoB_index,
  input  logic                    CDBRoB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRoB_RoB_index,
  input  logic [31:0]             CDBRoB_value,
  input  logic                    CDBRoB_jump,
  input  logic [31:0]             CDBRoB_next_pc,
  input  logic [RoB_WIDTH-1:0]    DPRoB_query_index,
  output logic                    RoBDP_query_ready,
  output logic [31:0]             RoBDP_query_value,
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic [31:0]             RoBIF_new_pc
);

  localparam logic [RoB_WIDTH:0]   SIZE_CNT = (RoB_WIDTH+1)'(RoB_SIZE);
  localparam logic [RoB_WIDTH-1:0] LAST_IDX = RoB_WIDTH'(RoB_SIZE - 1);

  logic [RoB_WIDTH-1:0] head_reg, tail_reg;
  logic [RoB_WIDTH:0]   count_reg;
  logic [RoB_SIZE-1:0]  busy_reg, ready_reg;

  logic [EX_REG_WIDTH-1:0] rd_reg     [RoB_SIZE];
  logic [31:0]             value_reg  [RoB_SIZE];
  logic [31:0]             npc_reg    [RoB_SIZE];
  logic                    branch_reg [RoB_SIZE];
  logic                    pred_reg   [RoB_SIZE];
  logic                    jump_reg   [RoB_SIZE];

  logic do_commit, mispredict, do_alloc, do_wb;

  function automatic logic [RoB_WIDTH-1:0] next_idx(input logic [RoB_WIDTH-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign RoBDP_full      = (count_reg == SIZE_CNT);
  assign RoBDP_RoB_index = tail_reg;

  // A mispredicting commit squashes everything else presented in the same cycle.
  always_comb begin
    do_commit  = Sys_rdy && (count_reg != '0) && busy_reg[head_reg] && ready_reg[head_reg];
    mispredict = do_commit && branch_reg[head_reg] && (jump_reg[head_reg] != pred_reg[head_reg]);
    do_alloc   = Sys_rdy && DPRoB_en && !RoBDP_full && !mispredict;
    do_wb      = Sys_rdy && CDBRoB_en && busy_reg[CDBRoB_RoB_index] && !mispredict;
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      busy_reg  <= '0;
      ready_reg <= '0;
    end else if (mispredict) begin
      busy_reg <= '0;
    end else begin
      if (do_commit) busy_reg[head_reg] <= 1'b0;
      if (do_alloc) begin
        busy_reg[tail_reg]  <= 1'b1;
        ready_reg[tail_reg] <= 1'b0;
      end
      if (do_wb) ready_reg[CDBRoB_RoB_index] <= 1'b1;
    end
  end

  // Payload fields need no reset: busy/ready qualify every read.
  always_ff @(posedge Sys_clk) begin
    if (do_alloc) begin
      rd_reg[tail_reg]     <= DPRoB_rd;
      branch_reg[tail_reg] <= DPRoB_is_branch;
      pred_reg[tail_reg]   <= DPRoB_pred_jump;
    end
    if (do_wb) begin
      value_reg[CDBRoB_RoB_index] <= CDBRoB_value;
      jump_reg[CDBRoB_RoB_index]  <= CDBRoB_jump;
      npc_reg[CDBRoB_RoB_index]   <= CDBRoB_next_pc;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      RoBRF_en        <= 1'b0;
      RoBRF_RoB_index <= '0;
      RoBRF_rd        <= NON_REG;
      RoBRF_value     <= '0;
      RoBRF_pre_judge <= 1'b1;
      RoBIF_new_pc    <= '0;
    end else if (Sys_rdy) begin
      RoBRF_en        <= do_commit;
      RoBRF_pre_judge <= !mispredict;
      if (do_commit) begin
        RoBRF_RoB_index <= head_reg;
        RoBRF_rd        <= branch_reg[head_reg] ? NON_REG : rd_reg[head_reg];
        RoBRF_value     <= value_reg[head_reg];
      end
      if (mispredict) begin
        RoBIF_new_pc <= npc_reg[head_reg];
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
      end else begin
        if (do_commit) head_reg <= next_idx(head_reg);
        if (do_alloc)  tail_reg <= next_idx(tail_reg);
        case ({do_alloc, do_commit})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

`ifdef ROB_FORWARD_EN
  logic cdb_hit;
  always_comb begin
    cdb_hit           = Sys_rdy && CDBRoB_en && (CDBRoB_RoB_index == DPRoB_query_index);
    RoBDP_query_ready = busy_reg[DPRoB_query_index] && (ready_reg[DPRoB_query_index] || cdb_hit);
    RoBDP_query_value = cdb_hit ? CDBRoB_value : value_reg[DPRoB_query_index];
  end
`else
  logic unused_query;
  assign unused_query      = ^DPRoB_query_index;
  assign RoBDP_query_ready = 1'b0;
  assign RoBDP_query_value = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of in-flight instructions.
module tb_reorder_buffer;
  localparam logic [5:0] NON_REG = 6'b100000;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy;
  logic        DPRoB_en, DPRoB_is_branch, DPRoB_pred_jump;
  logic [5:0]  DPRoB_rd;
  logic        RoBDP_full;
  logic [7:0]  RoBDP_RoB_index;
  logic        CDBRoB_en, CDBRoB_jump;
  logic [7:0]  CDBRoB_RoB_index;
  logic [31:0] CDBRoB_value, CDBRoB_next_pc;
  logic [7:0]  DPRoB_query_index;
  logic        RoBDP_query_ready;
  logic [31:0] RoBDP_query_value;
  logic        RoBRF_en, RoBRF_pre_judge;
  logic [7:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value, RoBIF_new_pc;

  reorder_buffer dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .DPRoB_en(DPRoB_en), .DPRoB_rd(DPRoB_rd), .DPRoB_is_branch(DPRoB_is_branch),
    .DPRoB_pred_jump(DPRoB_pred_jump), .RoBDP_full(RoBDP_full), .RoBDP_RoB_index(RoBDP_RoB_index),
    .CDBRoB_en(CDBRoB_en), .CDBRoB_RoB_index(CDBRoB_RoB_index), .CDBRoB_value(CDBRoB_value),
    .CDBRoB_jump(CDBRoB_jump), .CDBRoB_next_pc(CDBRoB_next_pc),
    .DPRoB_query_index(DPRoB_query_index), .RoBDP_query_ready(RoBDP_query_ready),
    .RoBDP_query_value(RoBDP_query_value), .RoBRF_en(RoBRF_en), .RoBRF_RoB_index(RoBRF_RoB_index),
    .RoBRF_rd(RoBRF_rd), .RoBRF_value(RoBRF_value), .RoBRF_pre_judge(RoBRF_pre_judge),
    .RoBIF_new_pc(RoBIF_new_pc)
  );

  always #5 Sys_clk = ~Sys_clk;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [7:0]  idx;
    logic [5:0]  rd;
    logic        br, pred, rdy, jmp;
    logic [31:0] val, npc;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  logic        exp_en, exp_pj, committed;
  logic [7:0]  exp_idx;
  logic [5:0]  exp_rd;
  logic [31:0] exp_val, exp_npc;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_tail  = 0;
    exp_en  = 1'b0;
    exp_idx = '0;
    exp_rd  = NON_REG;
    exp_val = '0;
    exp_pj  = 1'b1;
    exp_npc = '0;
  endtask

  task automatic model_step();
    bit was_full;
    bit commit;
    committed = 1'b0;
    if (!Sys_rdy) return;
    exp_en   = 1'b0;
    exp_pj   = 1'b1;
    was_full = (q.size() == 256);
    commit   = (q.size() > 0) && q[0].rdy;
    if (commit) begin
      committed = 1'b1;
      exp_en  = 1'b1;
      exp_idx = q[0].idx;
      exp_rd  = q[0].br ? NON_REG : q[0].rd;
      exp_val = q[0].val;
      if (q[0].br && (q[0].jmp != q[0].pred)) begin
        exp_pj  = 1'b0;
        exp_npc = q[0].npc;
        q.delete();
        m_tail = 0;
        return;
      end
    end
    if (CDBRoB_en)
      foreach (q[i])
        if (q[i].idx == CDBRoB_RoB_index) begin
          q[i].rdy = 1'b1;
          q[i].val = CDBRoB_value;
          q[i].jmp = CDBRoB_jump;
          q[i].npc = CDBRoB_next_pc;
        end
    if (commit) void'(q.pop_front());
    if (DPRoB_en && !was_full) begin
      ent_t e;
      e.idx = 8'(m_tail); e.rd = DPRoB_rd; e.br = DPRoB_is_branch; e.pred = DPRoB_pred_jump;
      e.rdy = 1'b0; e.jmp = 1'b0; e.val = '0; e.npc = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % 256;
    end
  endtask

  task automatic check_outputs();
    chk("en", RoBRF_en, exp_en);
    if (exp_en) begin
      chk("commit_idx", RoBRF_RoB_index, exp_idx);
      chk("commit_rd", RoBRF_rd, exp_rd);
      chk("commit_value", RoBRF_value, exp_val);
    end
    chk("pre_judge", RoBRF_pre_judge, exp_pj);
    if (!exp_pj) chk("new_pc", RoBIF_new_pc, exp_npc);
    chk("full", RoBDP_full, 32'(q.size() == 256));
    chk("tail", RoBDP_RoB_index, 32'(m_tail));
`ifndef ROB_FORWARD_EN
    chk("query_ready_off", RoBDP_query_ready, 0);
    chk("query_value_off", RoBDP_query_value, 0);
`endif
    if (committed)
      $display("commit idx=%0d rd=%0d value=%h pre_judge=%0b new_pc=%h",
               RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge, RoBIF_new_pc);
  endtask

  task automatic tick();
    model_step();
    @(posedge Sys_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    Sys_rdy = 1'b1; DPRoB_en = 1'b0; DPRoB_rd = '0; DPRoB_is_branch = 1'b0; DPRoB_pred_jump = 1'b0;
    CDBRoB_en = 1'b0; CDBRoB_RoB_index = '0; CDBRoB_value = '0; CDBRoB_jump = 1'b0;
    CDBRoB_next_pc = '0; DPRoB_query_index = '0;
  endtask

  task automatic set_alloc(input logic [5:0] rd, input logic br, input logic pj);
    DPRoB_en = 1'b1; DPRoB_rd = rd; DPRoB_is_branch = br; DPRoB_pred_jump = pj;
  endtask

  task automatic set_wb(input logic [7:0] idx, input logic [31:0] val, input logic jmp, input logic [31:0] npc);
    CDBRoB_en = 1'b1; CDBRoB_RoB_index = idx; CDBRoB_value = val; CDBRoB_jump = jmp; CDBRoB_next_pc = npc;
  endtask

  // Raise reset between clock edges and check the outputs before any edge arrives.
  task automatic apply_reset(input string tag);
    idle();
    Sys_rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_en"}, RoBRF_en, 0);
    chk({tag, "_idx"}, RoBRF_RoB_index, 0);
    chk({tag, "_rd"}, RoBRF_rd, NON_REG);
    chk({tag, "_value"}, RoBRF_value, 0);
    chk({tag, "_pre_judge"}, RoBRF_pre_judge, 1);
    chk({tag, "_new_pc"}, RoBIF_new_pc, 0);
    chk({tag, "_full"}, RoBDP_full, 0);
    chk({tag, "_tail"}, RoBDP_RoB_index, 0);
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
  endtask

  initial begin
    idle();
    Sys_rst = 1'b0;
    #2;
    apply_reset("reset");

    // In-order commit despite out-of-order writeback
    idle(); set_alloc(6'd5, 1'b0, 1'b0); tick();
    idle(); set_alloc(6'd7, 1'b0, 1'b0); tick();
    idle(); set_wb(8'd1, 32'h22, 1'b0, 32'h0); tick();
    chk("A_hold_for_head", RoBRF_en, 0);
    idle(); set_wb(8'd0, 32'h11, 1'b0, 32'h0); tick();
    chk("A_no_same_edge_commit", RoBRF_en, 0);
    idle(); tick();
    chk("A_c0_en", RoBRF_en, 1); chk("A_c0_idx", RoBRF_RoB_index, 0);
    chk("A_c0_rd", RoBRF_rd, 5); chk("A_c0_value", RoBRF_value, 32'h11);
    idle(); tick();
    chk("A_c1_en", RoBRF_en, 1); chk("A_c1_idx", RoBRF_RoB_index, 1);
    chk("A_c1_rd", RoBRF_rd, 7); chk("A_c1_value", RoBRF_value, 32'h22);
    idle(); tick();
    chk("A_pulse", RoBRF_en, 0);

    // Fill to capacity, allocate while full, drain through the wrap
    apply_reset("rstF");
    for (int i = 0; i < 256; i++) begin
      idle(); set_alloc(6'(i % 32), 1'b0, 1'b0); tick();
    end
    chk("F_full", RoBDP_full, 1); chk("F_tail_wrap", RoBDP_RoB_index, 0);
    idle(); set_alloc(6'd3, 1'b0, 1'b0); set_wb(8'd0, 32'hF0, 1'b0, 32'h0); tick();
    chk("F_alloc_ignored", RoBDP_full, 1);
    idle(); set_alloc(6'd4, 1'b0, 1'b0); tick();
    chk("F_commit_en", RoBRF_en, 1); chk("F_commit_value", RoBRF_value, 32'hF0);
    chk("F_not_full", RoBDP_full, 0); chk("F_tail_after", RoBDP_RoB_index, 0);
    for (int i = 1; i < 256; i++) begin
      idle(); set_wb(8'(i), 32'(i * 3), 1'b0, 32'h0); tick();
    end
    idle(); tick(); idle(); tick();
    chk("F_drained", RoBRF_en, 0);

    // Mispredicted branch: flush, redirect, discard same-cycle allocation
    apply_reset("rstM");
    idle(); set_alloc(6'd1, 1'b1, 1'b0); tick();
    idle(); set_alloc(6'd2, 1'b0, 1'b0); tick();
    idle(); set_wb(8'd1, 32'h77, 1'b0, 32'h0); tick();
    idle(); set_wb(8'd0, 32'h99, 1'b1, 32'h1000); tick();
    idle(); set_alloc(6'd3, 1'b0, 1'b0); tick();
    chk("M_en", RoBRF_en, 1); chk("M_rd", RoBRF_rd, NON_REG);
    chk("M_pre_judge", RoBRF_pre_judge, 0); chk("M_new_pc", RoBIF_new_pc, 32'h1000);
    chk("M_tail", RoBDP_RoB_index, 0);
    idle(); tick();
    chk("M_pj_one_cycle", RoBRF_pre_judge, 1); chk("M_younger_flushed", RoBRF_en, 0);
    idle(); set_alloc(6'd6, 1'b0, 1'b0); tick();
    idle(); set_wb(8'd0, 32'hAA, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("M_realloc_idx", RoBRF_RoB_index, 0); chk("M_realloc_rd", RoBRF_rd, 6);

    // Correctly predicted branch keeps younger entries
    apply_reset("rstB");
    idle(); set_alloc(6'd8, 1'b1, 1'b1); tick();
    idle(); set_alloc(6'd9, 1'b0, 1'b0); tick();
    idle(); set_alloc(6'd10, 1'b0, 1'b0); tick();
    idle(); set_wb(8'd0, 32'h5, 1'b1, 32'h2000); tick();
    idle(); tick();
    chk("B_en", RoBRF_en, 1); chk("B_rd", RoBRF_rd, NON_REG);
    chk("B_pre_judge", RoBRF_pre_judge, 1); chk("B_tail", RoBDP_RoB_index, 3);
    idle(); set_wb(8'd1, 32'h91, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("B_younger_idx", RoBRF_RoB_index, 1); chk("B_younger_rd", RoBRF_rd, 9);
    chk("B_younger_value", RoBRF_value, 32'h91);

    // Forwarding lookup during the writeback cycle
    apply_reset("rstQ");
    for (int i = 0; i < 4; i++) begin
      idle(); set_alloc(6'(i + 1), 1'b0, 1'b0); tick();
    end
    idle(); set_wb(8'd3, 32'hABCD, 1'b0, 32'h0); DPRoB_query_index = 8'd3;
    #1;
`ifdef ROB_FORWARD_EN
    chk("Q_ready", RoBDP_query_ready, 1); chk("Q_value", RoBDP_query_value, 32'hABCD);
`else
    chk("Q_ready_off", RoBDP_query_ready, 0); chk("Q_value_off", RoBDP_query_value, 0);
`endif
    tick();

    // Randomized traffic against the model
    apply_reset("rstR");
    for (int c = 0; c < 1500; c++) begin
      idle();
      Sys_rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0)
        set_alloc(($urandom_range(0, 7) == 0) ? NON_REG : 6'($urandom_range(0, 31)),
                  ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = int'($urandom_range(0, q.size() - 1));
        set_wb(q[k].idx, $urandom, q[k].pred ^ ($urandom_range(0, 3) == 0), $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        set_wb(8'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      tick();
    end

    // Reset between edges with ten entries in flight and a commit just visible
    apply_reset("rstD");
    for (int i = 0; i < 10; i++) begin
      idle(); set_alloc(6'(i + 20), 1'b0, 1'b0); tick();
    end
    idle(); set_wb(8'd0, 32'h55, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("D_pre_en", RoBRF_en, 1); chk("D_pre_value", RoBRF_value, 32'h55);
    #2;
    apply_reset("midrst");
    idle(); set_alloc(6'd12, 1'b0, 1'b0); tick();
    idle(); set_wb(8'd0, 32'h66, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("D_first_idx", RoBRF_RoB_index, 0); chk("D_first_rd", RoBRF_rd, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
